// File: rtl/wb_commit_queue_pkg.sv
// rtl/wb_commit_queue_pkg.sv - shared widths and constants for the write-back commit queue
package wb_commit_queue_pkg;

   // Default data width of a register-file write
   localparam int DATA_W_DEF = 32;
   // Default register address width (2**REG_AW registers)
   localparam int REG_AW_DEF = 5;
   // Default number of queue entries
   localparam int DEPTH_DEF  = 4;
   // Architectural zero register; writes to it are dropped before queueing
   localparam int REG_ZERO   = 0;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular buffer with up to two pushes and one pop per cycle
module wb_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int AW     = 5
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_push0,
   input  logic [AW-1:0]                      i_dest0,
   input  logic [DATA_W-1:0]                  i_data0,
   input  logic                               i_push1,
   input  logic [AW-1:0]                      i_dest1,
   input  logic [DATA_W-1:0]                  i_data1,
   input  logic                               i_pop,
   output logic [$clog2(DEPTH+1)-1:0]         o_count,
   output logic [AW-1:0]                      o_head_dest,
   output logic [DATA_W-1:0]                  o_head_data,
   output logic [DEPTH-1:0]                   o_ent_valid,
   output logic [DEPTH-1:0][AW-1:0]           o_ent_dest
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]     r_dest [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;

   logic [1:0]        w_npush;
   logic [PW-1:0]     w_slot1;

   // Pointer advance that wraps at DEPTH, so non-power-of-two depths work
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return s[PW-1:0];
   endfunction

   assign w_npush = {1'b0, i_push0} + {1'b0, i_push1};
   // The second write lands behind the primary when both push, else at the tail itself
   assign w_slot1 = i_push0 ? ptr_add(r_tail, 1) : r_tail;

   // Pointer/count update and entry writes; payload storage is not reset since count gates it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push0) begin
            r_dest[r_tail] <= i_dest0;
            r_data[r_tail] <= i_data0;
         end
         if (i_push1) begin
            r_dest[w_slot1] <= i_dest1;
            r_data[w_slot1] <= i_data1;
         end
         r_tail  <= ptr_add(r_tail, int'(w_npush));
         if (i_pop) r_head <= ptr_add(r_head, 1);
         r_count <= CW'(int'(r_count) + int'(w_npush) - int'(i_pop));
      end
   end

   // Per-entry valid/dest view: an entry is live when its distance from head is below count
   always_comb begin
      int off;
      off         = 0;
      o_ent_valid = '0;
      o_ent_dest  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = i - int'(r_head);
         if (off < 0) off = off + DEPTH;
         o_ent_valid[i] = (off < int'(r_count));
         o_ent_dest[i]  = r_dest[i];
      end
   end

   assign o_count     = r_count;
   assign o_head_dest = r_dest[r_head];
   assign o_head_data = r_data[r_head];

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (int'(r_count) + int'(w_npush) - int'(i_pop)) <= DEPTH);

endmodule

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - write-back queue retiring one register write per cycle
module wb_commit_queue
   import wb_commit_queue_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   WB_EN_in,
   input  logic                   MEM_R_EN_in,
   input  logic [DATA_W-1:0]      ALU_Result_in,
   input  logic [DATA_W-1:0]      Mem_Data_in,
   input  logic [REG_AW-1:0]      Dest_in,
   input  logic                   Dual_EN_in,
   input  logic [REG_AW-1:0]      Dest2_in,
   input  logic [DATA_W-1:0]      Data2_in,
   output logic                   wb_stall,
   output logic                   WB_Write_Enable,
   output logic [REG_AW-1:0]      WB_Dest,
   output logic [DATA_W-1:0]      WB_Data,
   output logic [2**REG_AW-1:0]   pending_mask
);

   localparam int CW = $clog2(DEPTH+1);

   logic [CW-1:0]               w_count;
   logic [REG_AW-1:0]           w_head_dest;
   logic [DATA_W-1:0]           w_head_data;
   logic [DEPTH-1:0]            w_ent_valid;
   logic [DEPTH-1:0][REG_AW-1:0] w_ent_dest;
   logic                        w_accept;
   logic                        w_push0;
   logic                        w_push1;
   logic                        w_pop;
   logic [DATA_W-1:0]           w_data0;

   // Stall only from registered occupancy: leaves room for a two-entry push alongside a pop
   assign wb_stall = (int'(w_count) > DEPTH - 2);
   assign w_accept = !wb_stall;
   assign w_data0  = MEM_R_EN_in ? Mem_Data_in : ALU_Result_in;
   assign w_push0  = w_accept && WB_EN_in   && (Dest_in  != REG_AW'(REG_ZERO));
   assign w_push1  = w_accept && Dual_EN_in && (Dest2_in != REG_AW'(REG_ZERO));
   assign w_pop    = (w_count != '0);

   wb_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (REG_AW)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push0     (w_push0),
      .i_dest0     (Dest_in),
      .i_data0     (w_data0),
      .i_push1     (w_push1),
      .i_dest1     (Dest2_in),
      .i_data1     (Data2_in),
      .i_pop       (w_pop),
      .o_count     (w_count),
      .o_head_dest (w_head_dest),
      .o_head_data (w_head_data),
      .o_ent_valid (w_ent_valid),
      .o_ent_dest  (w_ent_dest)
   );

   // Head entry drives the register-file write port; zeros when the queue is empty
   always_comb begin
      WB_Write_Enable = w_pop;
      WB_Dest         = w_pop ? w_head_dest : '0;
      WB_Data         = w_pop ? w_head_data : '0;
   end

   // Pending mask: one bit per register targeted by any live entry, head included
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_ent_valid[i]) pending_mask[w_ent_dest[i]] = 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - directed self-checking bench for wb_commit_queue
module tb_wb_commit_queue;

   logic        clk;
   logic        rst;
   logic        WB_EN_in;
   logic        MEM_R_EN_in;
   logic [31:0] ALU_Result_in;
   logic [31:0] Mem_Data_in;
   logic [4:0]  Dest_in;
   logic        Dual_EN_in;
   logic [4:0]  Dest2_in;
   logic [31:0] Data2_in;
   logic        wb_stall;
   logic        WB_Write_Enable;
   logic [4:0]  WB_Dest;
   logic [31:0] WB_Data;
   logic [31:0] pending_mask;

   int n_cmp;
   int n_fail;

   wb_commit_queue #(.DEPTH(4), .DATA_W(32), .REG_AW(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .WB_EN_in        (WB_EN_in),
      .MEM_R_EN_in     (MEM_R_EN_in),
      .ALU_Result_in   (ALU_Result_in),
      .Mem_Data_in     (Mem_Data_in),
      .Dest_in         (Dest_in),
      .Dual_EN_in      (Dual_EN_in),
      .Dest2_in        (Dest2_in),
      .Data2_in        (Data2_in),
      .wb_stall        (wb_stall),
      .WB_Write_Enable (WB_Write_Enable),
      .WB_Dest         (WB_Dest),
      .WB_Data         (WB_Data),
      .pending_mask    (pending_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      WB_EN_in = 0; MEM_R_EN_in = 0; ALU_Result_in = 0; Mem_Data_in = 0;
      Dest_in = 0; Dual_EN_in = 0; Dest2_in = 0; Data2_in = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      tick();
      tick();
      n_cmp++; if (WB_Write_Enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", WB_Write_Enable); end
      n_cmp++; if (WB_Dest !== 5'd0) begin n_fail++; $display("FAIL reset_dest got %0d exp 0", WB_Dest); end
      n_cmp++; if (WB_Data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", WB_Data); end
      n_cmp++; if (pending_mask !== 32'd0) begin n_fail++; $display("FAIL reset_mask got %h exp 0", pending_mask); end
      n_cmp++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", wb_stall); end
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++; if (WB_Write_Enable !== 1'b0) begin n_fail++; $display("FAIL idle_we cycle %0d got %b exp 0", i, WB_Write_Enable); end
      end
   endtask

   task automatic test_single_alu();
      WB_EN_in = 1; MEM_R_EN_in = 0; Dest_in = 5; ALU_Result_in = 32'h1234;
      tick();
      clear_inputs();
      n_cmp++; if (WB_Write_Enable !== 1'b1) begin n_fail++; $display("FAIL alu_we got %b exp 1", WB_Write_Enable); end
      n_cmp++; if (WB_Dest !== 5'd5) begin n_fail++; $display("FAIL alu_dest got %0d exp 5", WB_Dest); end
      n_cmp++; if (WB_Data !== 32'h1234) begin n_fail++; $display("FAIL alu_data got %h exp 1234", WB_Data); end
      n_cmp++; if (pending_mask !== 32'h20) begin n_fail++; $display("FAIL alu_mask got %h exp 20", pending_mask); end
      tick();
      n_cmp++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL alu_mask_clear got %h exp 0", pending_mask); end
      n_cmp++; if (WB_Write_Enable !== 1'b0) begin n_fail++; $display("FAIL alu_we_clear got %b exp 0", WB_Write_Enable); end
   endtask

   task automatic test_load_select();
      WB_EN_in = 1; MEM_R_EN_in = 1; Mem_Data_in = 32'hDEAD; ALU_Result_in = 32'hBEEF; Dest_in = 7;
      tick();
      clear_inputs();
      n_cmp++; if (WB_Data !== 32'hDEAD) begin n_fail++; $display("FAIL load_data got %h exp dead", WB_Data); end
      n_cmp++; if (WB_Dest !== 5'd7) begin n_fail++; $display("FAIL load_dest got %0d exp 7", WB_Dest); end
      tick();
   endtask

   task automatic test_swp();
      logic [31:0] r1;
      WB_EN_in = 1; Dest_in = 1; ALU_Result_in = 10; Dual_EN_in = 1; Dest2_in = 2; Data2_in = 20;
      tick();
      clear_inputs();
      n_cmp++; if ({WB_Write_Enable, WB_Dest, WB_Data} !== {1'b1, 5'd1, 32'd10}) begin n_fail++; $display("FAIL swp_first got %b/%0d/%0d exp 1/1/10", WB_Write_Enable, WB_Dest, WB_Data); end
      n_cmp++; if (pending_mask !== 32'h6) begin n_fail++; $display("FAIL swp_mask got %h exp 6", pending_mask); end
      tick();
      n_cmp++; if ({WB_Write_Enable, WB_Dest, WB_Data} !== {1'b1, 5'd2, 32'd20}) begin n_fail++; $display("FAIL swp_second got %b/%0d/%0d exp 1/2/20", WB_Write_Enable, WB_Dest, WB_Data); end
      n_cmp++; if (pending_mask !== 32'h4) begin n_fail++; $display("FAIL swp_mask2 got %h exp 4", pending_mask); end
      tick();
      n_cmp++; if (WB_Write_Enable !== 1'b0) begin n_fail++; $display("FAIL swp_done got %b exp 0", WB_Write_Enable); end
      // same destination twice: last write must win
      r1 = 32'hX;
      WB_EN_in = 1; Dest_in = 1; ALU_Result_in = 10; Dual_EN_in = 1; Dest2_in = 1; Data2_in = 20;
      tick();
      clear_inputs();
      n_cmp++; if (pending_mask !== 32'h2) begin n_fail++; $display("FAIL swp_dup_mask got %h exp 2", pending_mask); end
      for (int i = 0; i < 3; i++) begin
         if (WB_Write_Enable && WB_Dest == 5'd1) r1 = WB_Data;
         tick();
      end
      n_cmp++; if (r1 !== 32'd20) begin n_fail++; $display("FAIL swp_dup_r1 got %0d exp 20", r1); end
   endtask

   task automatic test_back_pressure();
      logic [4:0]  d1 [3];
      logic [4:0]  d2 [3];
      logic [4:0]  exp_dest [6];
      logic [31:0] exp_data [6];
      logic        exp_stall [7];
      int idx;
      int nret;
      logic acc;
      d1 = '{5'd3, 5'd5, 5'd7};
      d2 = '{5'd4, 5'd6, 5'd8};
      exp_dest  = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
      exp_data  = '{32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
      exp_stall = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      idx = 0;
      nret = 0;
      for (int c = 0; c < 12; c++) begin
         if (idx < 3) begin
            WB_EN_in = 1; MEM_R_EN_in = 0; Dest_in = d1[idx]; ALU_Result_in = {27'd0, d1[idx]} << 4;
            Dual_EN_in = 1; Dest2_in = d2[idx]; Data2_in = {27'd0, d2[idx]} << 4;
         end else begin
            clear_inputs();
         end
         acc = !wb_stall && (idx < 3);
         tick();
         if (acc) idx++;
         if (c < 7) begin
            n_cmp++; if (wb_stall !== exp_stall[c]) begin n_fail++; $display("FAIL bp_stall cycle %0d got %b exp %b", c, wb_stall, exp_stall[c]); end
         end
         if (WB_Write_Enable === 1'b1) begin
            n_cmp++;
            if (nret >= 6) begin
               n_fail++; $display("FAIL bp_extra_retire got dest %0d exp none", WB_Dest);
            end else if ({WB_Dest, WB_Data} !== {exp_dest[nret], exp_data[nret]}) begin
               n_fail++; $display("FAIL bp_retire_%0d got %0d/%h exp %0d/%h", nret, WB_Dest, WB_Data, exp_dest[nret], exp_data[nret]);
            end
            nret++;
         end
      end
      clear_inputs();
      n_cmp++; if (nret !== 6) begin n_fail++; $display("FAIL bp_retire_count got %0d exp 6", nret); end
   endtask

   task automatic test_reg0_and_reset();
      WB_EN_in = 1; Dest_in = 0; ALU_Result_in = 32'h55;
      tick();
      clear_inputs();
      n_cmp++; if (WB_Write_Enable !== 1'b0) begin n_fail++; $display("FAIL r0_we got %b exp 0", WB_Write_Enable); end
      n_cmp++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL r0_mask got %h exp 0", pending_mask); end
      WB_EN_in = 1; Dest_in = 0; ALU_Result_in = 32'h66; Dual_EN_in = 1; Dest2_in = 9; Data2_in = 32'h99;
      tick();
      clear_inputs();
      n_cmp++; if ({WB_Write_Enable, WB_Dest, WB_Data} !== {1'b1, 5'd9, 32'h99}) begin n_fail++; $display("FAIL r0_second got %b/%0d/%h exp 1/9/99", WB_Write_Enable, WB_Dest, WB_Data); end
      n_cmp++; if (pending_mask !== 32'h200) begin n_fail++; $display("FAIL r0_second_mask got %h exp 200", pending_mask); end
      tick();
      // two SWPs back to back leave three entries queued
      WB_EN_in = 1; Dest_in = 10; ALU_Result_in = 32'hA; Dual_EN_in = 1; Dest2_in = 11; Data2_in = 32'hB;
      tick();
      Dest_in = 12; ALU_Result_in = 32'hC; Dest2_in = 13; Data2_in = 32'hD;
      tick();
      clear_inputs();
      n_cmp++; if (pending_mask !== 32'h3800) begin n_fail++; $display("FAIL mid_mask got %h exp 3800", pending_mask); end
      rst = 1;
      tick();
      rst = 0;
      n_cmp++; if (WB_Write_Enable !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we got %b exp 0", WB_Write_Enable); end
      n_cmp++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL mid_rst_mask got %h exp 0", pending_mask); end
      n_cmp++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall got %b exp 0", wb_stall); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (WB_Write_Enable !== 1'b0) begin n_fail++; $display("FAIL post_rst_we cycle %0d got %b exp 0", i, WB_Write_Enable); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst = 1;
      clear_inputs();
      test_reset();
      test_single_alu();
      test_load_select();
      test_swp();
      test_back_pressure();
      test_reg0_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
